// File: rtl/inst_enc_pkg.sv
// -----------------------------------------------------------------------------
// inst_enc_pkg
// Shared definitions for the MIPS-subset instruction encoder:
//   - op_e        : the 17 mnemonic ids driven on inst_encoder.in_op
//   - OPC_* / FN_*: 6-bit major opcodes and R-type function codes
//   - state_e     : encoder FSM states
//   - helpers     : legality test and R/I/J field packers
// -----------------------------------------------------------------------------
package inst_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADDU  = 5'd0,
        OP_SUBU  = 5'd1,
        OP_ADD   = 5'd2,
        OP_AND   = 5'd3,
        OP_OR    = 5'd4,
        OP_SLT   = 5'd5,
        OP_JR    = 5'd6,
        OP_ADDI  = 5'd7,
        OP_ADDIU = 5'd8,
        OP_ANDI  = 5'd9,
        OP_ORI   = 5'd10,
        OP_LUI   = 5'd11,
        OP_SW    = 5'd12,
        OP_LW    = 5'd13,
        OP_BEQ   = 5'd14,
        OP_J     = 5'd15,
        OP_JAL   = 5'd16
    } op_e;

    // Major opcodes
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Ids above OP_JAL are not mnemonics.
    function automatic logic is_legal_op(input logic [4:0] op);
        return (op <= OP_JAL);
    endfunction

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational field packer: turns a mnemonic id plus operand fields
// into a 32-bit instruction word. Unknown ids produce 0x00000000 (NOP).
// Ports:
//   op     in  5   mnemonic id (inst_enc_pkg::op_e)
//   rs/rt/rd in 5  register fields
//   imm    in  16  immediate / branch offset
//   target in  26  jump target
//   word   out 32  encoded instruction
// -----------------------------------------------------------------------------
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word
);

    always_comb begin
        word = 32'h0000_0000;
        case (op)
            OP_ADDU:  word = r_word(rs, rt, rd, FN_ADDU);
            OP_SUBU:  word = r_word(rs, rt, rd, FN_SUBU);
            OP_ADD:   word = r_word(rs, rt, rd, FN_ADD);
            OP_AND:   word = r_word(rs, rt, rd, FN_AND);
            OP_OR:    word = r_word(rs, rt, rd, FN_OR);
            OP_SLT:   word = r_word(rs, rt, rd, FN_SLT);
            // JR only reads rs; rt and rd must encode as zero.
            OP_JR:    word = r_word(rs, 5'd0, 5'd0, FN_JR);
            OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm);
            OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm);
            OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm);
            // LUI has no source register; rs is forced to zero.
            OP_LUI:   word = i_word(OPC_LUI, 5'd0, rt, imm);
            OP_SW:    word = i_word(OPC_SW, rs, rt, imm);
            OP_LW:    word = i_word(OPC_LW, rs, rt, imm);
            OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm);
            OP_J:     word = j_word(OPC_J, target);
            OP_JAL:   word = j_word(OPC_JAL, target);
            default:  word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Accepts one instruction request at a time, encodes it through inst_pack and
// writes it to instruction memory with a one-cycle strobe at consecutive word
// addresses starting at BASE_ADDR. Ends in DONE after in_last, or in ERR when
// memory would overflow; start re-arms from either.
// Optional build macro: INST_ENC_ILLEGAL_CHECK_EN -- when defined, an unknown
// in_op is consumed without a write and sends the FSM to ERR; otherwise it is
// written as a NOP (0x00000000).
// Ports:
//   clk, reset (sync, active-low), start
//   in_valid/in_ready handshake, in_op, in_rs, in_rt, in_rd, in_imm,
//   in_target, in_last
//   imem_we, imem_addr[IMEM_AW], imem_wdata[32]
//   count[IMEM_AW+1], done, err
// -----------------------------------------------------------------------------
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int IMEM_AW   = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_op,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [15:0]        in_imm,
    input  logic [25:0]        in_target,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [IMEM_AW:0]   count,
    output logic               done,
    output logic               err
);

    localparam logic [IMEM_AW-1:0] BASE      = IMEM_AW'(BASE_ADDR);
    localparam logic [IMEM_AW-1:0] LAST_ADDR = '1;
    localparam logic [IMEM_AW-1:0] ADDR_ONE  = 1;
    localparam logic [IMEM_AW:0]   CNT_ONE   = 1;

    state_e      state_reg;
    logic        last_reg;
    logic [31:0] pack_word;
    logic        take;

    inst_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .word   (pack_word)
    );

    // in_ready is a pure decode of the state register.
    assign in_ready = (state_reg == ST_IDLE);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            last_reg   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'h0000_0000;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (take) begin
`ifdef INST_ENC_ILLEGAL_CHECK_EN
                        if (!is_legal_op(in_op)) begin
                            state_reg <= ST_ERR;
                            err       <= 1'b1;
                        end else begin
                            imem_wdata <= pack_word;
                            imem_we    <= 1'b1;
                            last_reg   <= in_last;
                            state_reg  <= ST_WRITE;
                        end
`else
                        imem_wdata <= pack_word;
                        imem_we    <= 1'b1;
                        last_reg   <= in_last;
                        state_reg  <= ST_WRITE;
`endif
                    end
                end
                ST_WRITE: begin
                    imem_addr <= imem_addr + ADDR_ONE;
                    count     <= count + CNT_ONE;
                    if (last_reg) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                    end else if (imem_addr == LAST_ADDR) begin
                        // Memory is full and the program is not finished:
                        // refuse to wrap over address 0.
                        state_reg <= ST_ERR;
                        err       <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg <= ST_IDLE;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        count     <= '0;
                        imem_addr <= BASE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Self-checking bench for inst_encoder with IMEM_AW=2 so memory-full behaviour
// is reachable in a few words. A vector table covers every mnemonic; the
// expected write for each accepted request is queued when driven and popped
// when the write strobe appears. Hand sequences cover start handling,
// overflow, illegal op and reset during a write.
// -----------------------------------------------------------------------------
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0;
    logic [4:0]    in_rs = '0;
    logic [4:0]    in_rt = '0;
    logic [4:0]    in_rd = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    inst_encoder #(.IMEM_AW(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } wr_t;

    vec_t          vecs [17];
    wr_t           exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            we_count = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW:0]   exp_count = '0;

    // Count every cycle the write strobe is high.
    always @(posedge clk) begin
        if (imem_we === 1'b1) we_count <= we_count + 1;
    end

    function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                                input logic last, input logic [31:0] word);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.imm = imm; v.tgt = tgt; v.last = last; v.word = word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic chk_armed(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
        chk({tag, "_count"}, 32'(count),    32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    endtask

    task automatic drive(input vec_t v);
        in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
        in_imm = v.imm; in_target = v.tgt; in_last = v.last;
        in_valid = 1'b1;
    endtask

    // Pop the oldest expected write and compare it with the strobe now visible.
    task automatic pop_cmp;
        wr_t e;
        chk("we_seen", 32'(imem_we), 32'd1);
        if (imem_we === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(e.addr));
            chk("wr_data", imem_wdata, e.word);
        end
    endtask

    // Called at posedge+1. Waits for in_ready, presents one request for one
    // edge, then follows the write (if expected) to completion.
    task automatic send(input vec_t v, input bit expect_wr);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        drive(v);
        if (expect_wr) exp_q.push_back('{addr: exp_addr, word: v.word});
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (expect_wr) begin
            n = 0;
            while (imem_we !== 1'b1 && n < 4) begin
                @(posedge clk); #1; n++;
            end
            pop_cmp();
            @(posedge clk); #1;
            chk("we_one_cycle", 32'(imem_we), 32'd0);
            exp_addr  = exp_addr + AW'(1);
            exp_count = exp_count + (AW+1)'(1);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   wc;
        vec_t v;

        // Groups end with last=1; no group exceeds the 4-word memory.
        vecs[0]  = mk(OP_ADDU,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b1, 32'h0022_1821);
        vecs[1]  = mk(OP_ORI,   5'd0,  5'd1,  5'd0,  16'h1234, 26'h0,       1'b0, 32'h3401_1234);
        vecs[2]  = mk(OP_LUI,   5'd7,  5'd2,  5'd0,  16'hABCD, 26'h0,       1'b0, 32'h3C02_ABCD);
        vecs[3]  = mk(OP_SUBU,  5'd4,  5'd5,  5'd6,  16'h0,    26'h0,       1'b0, 32'h0085_3023);
        vecs[4]  = mk(OP_ADD,   5'd31, 5'd31, 5'd31, 16'h0,    26'h0,       1'b1, 32'h03FF_F820);
        vecs[5]  = mk(OP_SW,    5'd4,  5'd5,  5'd0,  16'h0008, 26'h0,       1'b0, 32'hAC85_0008);
        vecs[6]  = mk(OP_BEQ,   5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b0, 32'h1022_FFFF);
        vecs[7]  = mk(OP_JAL,   5'd0,  5'd0,  5'd0,  16'h0,    26'h100,     1'b1, 32'h0C00_0100);
        vecs[8]  = mk(OP_AND,   5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b0, 32'h0022_1824);
        vecs[9]  = mk(OP_OR,    5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b0, 32'h0022_1825);
        vecs[10] = mk(OP_SLT,   5'd8,  5'd9,  5'd10, 16'h0,    26'h0,       1'b0, 32'h0109_502A);
        vecs[11] = mk(OP_JR,    5'd31, 5'd5,  5'd7,  16'h0,    26'h0,       1'b1, 32'h03E0_0008);
        vecs[12] = mk(OP_ADDI,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b0, 32'h2022_FFFF);
        vecs[13] = mk(OP_ADDIU, 5'd3,  5'd4,  5'd0,  16'h0010, 26'h0,       1'b0, 32'h2464_0010);
        vecs[14] = mk(OP_ANDI,  5'd5,  5'd6,  5'd0,  16'h00FF, 26'h0,       1'b0, 32'h30A6_00FF);
        vecs[15] = mk(OP_LW,    5'd29, 5'd31, 5'd0,  16'h0004, 26'h0,       1'b1, 32'h8FBF_0004);
        vecs[16] = mk(OP_J,     5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1'b1, 32'h0BFF_FFFF);

        do_reset();
        chk("rst_we",    32'(imem_we),  32'd0);
        chk("rst_wdata", imem_wdata,    32'd0);
        chk_armed("rst");

        // Table: every mnemonic, grouped into programs.
        exp_addr = '0; exp_count = '0;
        for (int i = 0; i < 17; i++) begin
            send(vecs[i], 1'b1);
            if (vecs[i].last) begin
                chk("prog_done",  32'(done),     32'd1);
                chk("prog_count", 32'(count),    32'(exp_count));
                chk("prog_ready", 32'(in_ready), 32'd0);
                chk("prog_err",   32'(err),      32'd0);
                pulse_start();
                chk_armed("rearm");
                exp_addr = '0; exp_count = '0;
            end
        end

        // start in IDLE is ignored.
        send(vecs[1], 1'b1);
        pulse_start();
        chk("idle_start_addr",  32'(imem_addr), 32'd1);
        chk("idle_start_count", 32'(count),     32'd1);

        // start during WRITE is ignored.
        drive(vecs[3]);
        exp_q.push_back('{addr: exp_addr, word: vecs[3].word});
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b1;
        pop_cmp();
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = exp_addr + AW'(1); exp_count = exp_count + (AW+1)'(1);
        chk("wr_start_addr",  32'(imem_addr), 32'd2);
        chk("wr_start_count", 32'(count),     32'd2);
        chk("wr_start_ready", 32'(in_ready),  32'd1);

        // Fill the last two words without in_last: overflow to ERR.
        send(vecs[8], 1'b1);
        send(vecs[9], 1'b1);
        chk("ovf_err",   32'(err),      32'd1);
        chk("ovf_done",  32'(done),     32'd0);
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_count", 32'(count),    32'd4);
        wc = we_count;
        drive(vecs[10]);
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ovf_no_fifth_write", 32'(we_count), 32'(wc));
        chk("ovf_err_sticky", 32'(err), 32'd1);
        pulse_start();
        chk_armed("ovf_rearm");
        exp_addr = '0; exp_count = '0;

        // Illegal op id.
        v = mk(5'd31, 5'd1, 5'd2, 5'd3, 16'h5555, 26'h0, 1'b0, 32'h0000_0000);
`ifdef INST_ENC_ILLEGAL_CHECK_EN
        wc = we_count;
        send(v, 1'b0);
        chk("ill_err",      32'(err),      32'd1);
        chk("ill_ready",    32'(in_ready), 32'd0);
        chk("ill_no_write", 32'(we_count), 32'(wc));
        chk("ill_count",    32'(count),    32'd0);
        pulse_start();
        chk_armed("ill_rearm");
`else
        send(v, 1'b1);
        chk("ill_err",   32'(err),      32'd0);
        chk("ill_ready", 32'(in_ready), 32'd1);
        chk("ill_count", 32'(count),    32'd1);
`endif

        // Reset asserted while a write is in flight.
        drive(vecs[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rw_we_before", 32'(imem_we), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rw_we",    32'(imem_we), 32'd0);
        chk("rw_wdata", imem_wdata,   32'd0);
        chk_armed("rw");
        reset = 1'b1;
        @(posedge clk); #1;
        exp_addr = '0; exp_count = '0;
        send(vecs[0], 1'b1);
        chk("post_rst_done", 32'(done), 32'd1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter IMEM_AW, default 10, instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written after reset or start.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  pulse that re-arms the encoder from DONE or ERR.
REQ-006 SHALL have port in_valid  input  1  instruction request valid.
REQ-007 SHALL have port in_ready  output  1  encoder can accept a request.
REQ-008 SHALL have port in_op  input  5  mnemonic id from the shared op enum.
REQ-009 SHALL have port in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-010 SHALL have port in_imm  input  16  immediate or branch offset.
REQ-011 SHALL have port in_target  input  26  jump target field.
REQ-012 SHALL have port in_last  input  1  final instruction of the program.
REQ-013 SHALL have port imem_we  output  1  one-cycle write strobe.
REQ-014 SHALL have port imem_addr  output  IMEM_AW  word address.
REQ-015 SHALL have port imem_wdata  output  32  encoded instruction.
REQ-016 SHALL have port count  output  IMEM_AW+1  words written since arm.
REQ-017 SHALL have ports done, err  output  1 each  program complete; sticky error.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, DONE, ERR.
REQ-019 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-020 On acceptance the FSM SHALL enter WRITE and register the encoded word; imem_we SHALL be 1 for exactly the WRITE cycle (latency 1, throughput 1 word per 2 cycles).
REQ-021 R-type encoding: opcode 000000, rs, rt, rd, shamt 0, funct ADDU 100001, SUBU 100011, ADD 100000, AND 100100, OR 100101, SLT 101010, JR 001000 (rt=rd=0).
REQ-022 I-type encoding: opcode ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, LUI 001111 (rs forced 0), SW 101011, LW 100011, BEQ 000100; fields rs, rt, imm unchanged.
REQ-023 J-type encoding: opcode J 000010, JAL 000011, target in bits 25:0.
REQ-024 After WRITE: address and count SHALL increment; next state DONE if the captured in_last was 1, else IDLE.
REQ-025 If the accepted write lands at address 2^IMEM_AW-1 and in_last was 0, the FSM SHALL enter ERR (no wrap-around write).
REQ-026 In DONE and ERR, in_ready SHALL be 0; start SHALL return the FSM to IDLE, clear done, err and count, and reload imem_addr to BASE_ADDR.
REQ-027 A start pulse in IDLE or WRITE SHALL be ignored.

Reset
REQ-028 When reset is 0 at a clock edge: state IDLE, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, done 0, err 0. A write in progress SHALL be aborted.

Configuration
REQ-029 With INST_ENC_ILLEGAL_CHECK_EN defined, an in_op outside the enum SHALL be accepted, produce no write, and move the FSM to ERR.
REQ-030 Without INST_ENC_ILLEGAL_CHECK_EN, an illegal in_op SHALL be written as 0x00000000 (NOP) and the FSM SHALL proceed normally.

Structure
REQ-031 The op enum (17 mnemonics), opcode constants, and funct constants SHALL live in the shared package inst_enc_pkg.
REQ-032 Combinational field packing SHALL be a sub-module named inst_pack; inst_encoder SHALL hold the FSM, counters, and output register.

Verification
REQ-033 ADDU rs=1 rt=2 rd=3 -> imem_wdata 0x00221821, imem_we for one cycle at address 0.
REQ-034 ORI rt=1 imm=0x1234, then LUI rt=2 rs=7 imm=0xABCD -> 0x34011234 at address 0, 0x3C02ABCD at address 1 (rs ignored).
REQ-035 SW rs=4 rt=5 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; JAL target=0x100 with in_last=1 -> 0xAC850008, 0x1022FFFF, 0x0C000100; then done=1, count=3, in_ready=0.
REQ-036 IMEM_AW=2: 4 words with in_last=0 -> err=1 after the fourth write, no fifth write; start -> IDLE, imem_addr=0.
REQ-037 Illegal in_op=31 -> with the macro: err=1, no write; without the macro: 0x00000000 written.
REQ-038 reset=0 during WRITE -> imem_we=0 on the next cycle, all outputs at reset values.
